// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and default geometry.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } fetch_state_e;

  localparam int unsigned DefAddrW  = 4;
  localparam int unsigned DefInstrW = 16;
  localparam logic [15:0] HaltInstr = 16'hFFFF;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the PC through a combinational instruction memory and
// presents one instruction per cycle behind a valid/ready handshake, with redirect and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W     = DefAddrW,
  parameter int unsigned          INSTR_W    = DefInstrW,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = INSTR_W'(HaltInstr)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted,
  output logic [7:0]         fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic [7:0]         fetch_count_q, fetch_count_d;

  logic xfer;
  logic load;

  assign xfer = out_valid_q & out_ready;
  assign load = (state_q == StRun) & (~out_valid_q | out_ready) & ~redirect_valid;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (load) begin
          out_instr_d = imem_data;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          if (imem_data != HALT_INSTR) begin
            pc_d = pc_q + ADDR_W'(1);
          end else begin
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        // The halt instruction stays on the output until the consumer takes it.
        if (xfer) begin
          out_valid_d = 1'b0;
        end
        if (redirect_valid) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect flushes the output stage in every state; a coincident handshake still counts.
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
    end

    if (xfer && (fetch_count_q != 8'hFF)) begin
      fetch_count_d = fetch_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign halted      = (state_q == StHalt);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected transfers, a monitor checks them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [3:0]  out_pc;
  logic        halted;
  logic [7:0]  fetch_count;

  logic [15:0] mem [16];

  typedef struct packed {
    logic [15:0] instr;
    logic [3:0]  pc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected: got instr=%h pc=%0d, scoreboard empty", out_instr, out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_instr !== e.instr || out_pc !== e.pc) begin
          bad++;
          $display("FAIL xfer: got instr=%h pc=%0d, want instr=%h pc=%0d",
                   out_instr, out_pc, e.instr, e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] instr, input logic [3:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      push(16'(i % 16), 4'(i % 16));
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits until every queued transfer has been observed, then stops the consumer on the next
  // edge so the last observed transfer actually completes.
  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d transfers outstanding, want 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_instr(input string name, input logic [15:0] v, input int bound);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(out_valid && out_instr == v) && n < bound);
    total++;
    if (!(out_valid && out_instr == v)) begin
      bad++;
      $display("FAIL %s_wait: got instr=%h valid=%b, want instr=%h valid=1",
               name, out_instr, out_valid, v);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);

    // Reset values and sequential fetch with wrap.
    rst = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    do_reset();
    push_seq(0, 18);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("start_no_fetch", 32'(out_valid), 32'd0);
    chk("start_addr", 32'(imem_addr), 32'd0);
    drain("seq", 40);
    chk("seq_count", 32'(fetch_count), 32'd18);

    // Backpressure stall while instruction 5 is presented.
    do_reset();
    push_seq(0, 10);
    start     = 1'b1;
    out_ready = 1'b1;
    wait_instr("stall", 16'd5, 20);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall_instr", 32'(out_instr), 32'd5);
      chk("stall_pc", 32'(out_pc), 32'd5);
      chk("stall_addr", 32'(imem_addr), 32'd6);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    drain("stall", 30);
    chk("stall_count", 32'(fetch_count), 32'd10);

    // Redirect while instruction 3 is being accepted.
    do_reset();
    push_seq(0, 4);
    push(16'd12, 4'd12);
    push(16'd13, 4'd13);
    start     = 1'b1;
    out_ready = 1'b1;
    wait_instr("redir", 16'd3, 20);
    redirect_valid = 1'b1;
    redirect_pc    = 4'd12;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    chk("redir_flush", 32'(out_valid), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'd12);
    drain("redir", 20);
    chk("redir_count", 32'(fetch_count), 32'd6);

    // Halt on HALT_INSTR at address 4, then restart by redirect.
    mem[4] = 16'hFFFF;
    do_reset();
    push_seq(0, 4);
    push(16'hFFFF, 4'd4);
    start     = 1'b1;
    out_ready = 1'b1;
    wait_instr("halt", 16'hFFFF, 20);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(out_pc), 32'd4);
    chk("halt_addr", 32'(imem_addr), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("halt_idle_valid", 32'(out_valid), 32'd0);
    chk("halt_still", 32'(halted), 32'd1);
    chk("halt_addr_held", 32'(imem_addr), 32'd4);
    chk("halt_sb_empty", 32'(sb.size()), 32'd0);
    push(16'd9, 4'd9);
    push(16'd10, 4'd10);
    redirect_valid = 1'b1;
    redirect_pc    = 4'd9;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    chk("halt_exit", 32'(halted), 32'd0);
    chk("halt_exit_addr", 32'(imem_addr), 32'd9);
    drain("halt", 20);
    mem[4] = 16'd4;

    // Asynchronous reset with an output pending.
    do_reset();
    start = 1'b1;
    wait_instr("arst", 16'd0, 10);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_instr", 32'(out_instr), 32'd0);
    chk("arst_pc", 32'(out_pc), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("arst_idle", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Counter saturation.
    do_reset();
    push_seq(0, 300);
    start     = 1'b1;
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("sat_drain", 32'(sb.size()), 32'd0);
    end
    push_seq(300, 5);
    @(posedge clk);
    #1;
    chk("sat_255", 32'(fetch_count), 32'd255);
    drain("sat", 20);
    chk("sat_hold", 32'(fetch_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: ADDR_W, default 4, PC / instruction-memory address width.
REQ-002 Parameter: INSTR_W, default 16, instruction width.
REQ-003 Parameter: HALT_INSTR, default 16'hFFFF, encoding that stops fetching.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: start  input  1  level; leaves IDLE.
REQ-007 Port: imem_addr  output  ADDR_W  address to instruction memory; equals pc register.
REQ-008 Port: imem_data  input  INSTR_W  instruction memory read data, combinational from imem_addr, same cycle.
REQ-009 Port: redirect_valid  input  1  branch/jump redirect request.
REQ-010 Port: redirect_pc  input  ADDR_W  redirect target.
REQ-011 Port: out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-012 Port: out_ready  input  1  downstream accepts when out_valid&out_ready.
REQ-013 Port: out_instr  output  INSTR_W  fetched instruction.
REQ-014 Port: out_pc  output  ADDR_W  address out_instr was fetched from.
REQ-015 Port: halted  output  1  high while in HALT state.
REQ-016 Port: fetch_count  output  8  accepted-transfer count, saturating.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, and HALT; halted is 1 only in HALT.
REQ-018 In IDLE, start=1 SHALL move the FSM to RUN next cycle with no fetch in that cycle.
REQ-019 In RUN, "load" SHALL be (out_valid==0 || out_ready==1) && redirect_valid==0.
REQ-020 On load: out_instr<=imem_data, out_pc<=pc, out_valid<=1; if imem_data!=HALT_INSTR then pc<=pc+1, else pc held and state<=HALT.
REQ-021 PC increment SHALL wrap modulo 2^ADDR_W (15 -> 0 at default).
REQ-022 In RUN without load and without redirect, pc, out_instr, out_pc, and out_valid SHALL hold (stall; outputs stable while out_valid&!out_ready).
REQ-023 Throughput SHALL be one instruction per cycle when out_ready is held at 1; latency from pc to out_valid is 1 cycle.
REQ-024 redirect_valid=1 in any state SHALL set pc<=redirect_pc and out_valid<=0 (flush) next cycle, taking priority over load.
REQ-025 Redirect in HALT SHALL move the FSM to RUN; redirect in IDLE or RUN SHALL leave the state unchanged.
REQ-026 Redirect coincident with out_valid&out_ready SHALL still count that transfer; the flush applies afterwards.
REQ-027 In HALT, no further fetches SHALL occur; the HALT_INSTR output remains valid until accepted, then out_valid<=0.
REQ-028 start SHALL be ignored in RUN and HALT.
REQ-029 fetch_count SHALL increment on each cycle with out_valid&out_ready and saturate at 255.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, pc=0, out_valid=0, out_instr=0, out_pc=0, fetch_count=0, halted=0.
REQ-031 Reset asserted mid-RUN SHALL discard any pending output without a handshake; after release the block waits for start.

Structure
REQ-032 The shared package SHALL hold the FSM state enum (IDLE/RUN/HALT), the default ADDR_W/INSTR_W, and the HALT_INSTR constant.
REQ-033 The block SHALL be a single module with no sub-module; it connects directly to the existing 16x16 instruction memory (addr -> instruction).

Verification
REQ-034 Bench memory model SHALL hold mem[i]=i except where a scenario states otherwise.
REQ-035 Reset, start=1, out_ready=1 held -> out_instr 0,1,...,15,0,1 on consecutive cycles, out_pc matching, wrap 15->0, fetch_count=18 after 18 transfers.
REQ-036 out_ready=0 for 3 cycles while out_instr=5 -> out_instr/out_pc stay 5, imem_addr stays 6; after release the next value is 6, with no skip or duplicate.
REQ-037 redirect_valid=1, redirect_pc=12 while out_instr=3 valid -> next cycle out_valid=0, imem_addr=12; the following outputs are 12,13.
REQ-038 mem[4]=16'hFFFF -> outputs 0..3 then FFFF with out_pc=4, halted=1, imem_addr held at 4, no further valid after acceptance; then redirect to 9 -> RUN, outputs 9,10.
REQ-039 rst asserted asynchronously mid-stream with out_valid=1 -> outputs clear immediately without a clock edge, state IDLE; with start=0, no out_valid for 10 cycles.
REQ-040 300 transfers -> fetch_count=255 and remains 255.
